encoded_byte_serializer: RTL
============================

Name: encoded_byte_serializer

Overview:
Transmit stage directly downstream of the combinational 8-bit encoder/decoder stages. It accepts encoded bytes over a valid/ready handshake and buffers up to two of them. It shifts each byte out on a single serial line as an 11-bit frame: start, 8 data bits LSB-first, parity, stop. A programmable bit period sets the line rate.

Parameters:
CLKS_PER_BIT, 4, clock cycles per serial bit; legal range >= 1.
PARITY_ODD, 0, 0 = even parity, 1 = odd parity.

Ports:
clk  input  1  system clock; all logic on rising edge.
rst_n  input  1  synchronous reset, active-low.
in_data  input  8  encoded byte from the encoder stage.
in_valid  input  1  in_data is valid.
in_ready  output  1  block can accept a byte this cycle.
tx_serial  output  1  serial line; idles high.
tx_busy  output  1  high while a frame is being transmitted.
frame_done  output  1  one-cycle pulse after each frame's stop bit.

Behaviour:
- Reset: one clock and one reset; reset is synchronous and active-low.
  - On any rising edge with rst_n low: state=IDLE, tx_serial=1, tx_busy=0, frame_done=0, FIFO emptied, bit/cycle counters=0.
  - in_ready is combinationally forced to 0 while rst_n is low. Writes are ignored during reset.
- Handshake:
  - A byte is accepted on any rising edge where in_valid && in_ready.
  - in_ready = !fifo_full. FIFO depth is 2; the byte currently being shifted is held separately in a shift register.
  - in_data must hold stable while in_valid && !in_ready.
- States: IDLE -> START -> DATA -> PARITY -> STOP -> (START | IDLE).
- Bit timing:
  - Each state holds for CLKS_PER_BIT cycles, counted by a cycle counter from 0 to CLKS_PER_BIT-1.
  - DATA uses a 3-bit index 0..7 and advances on each bit-period end.
- Line levels by state:
  - IDLE: tx_serial=1.
  - START: tx_serial=0.
  - DATA: tx_serial = shreg[idx], LSB first.
  - PARITY: tx_serial = ^byte XOR PARITY_ODD.
  - STOP: tx_serial=1.
- tx_serial is registered.
- Latency:
  - A byte accepted at edge E0 into an empty FIFO while IDLE is popped at edge E1.
  - At E1 the state becomes START and tx_serial goes low.
  - The frame occupies exactly 11*CLKS_PER_BIT cycles.
- Back-to-back frames:
  - At the end of STOP, if the FIFO is non-empty, pop and go directly to START with no idle cycle.
  - Otherwise go to IDLE.
- frame_done: registered; high for exactly the one cycle following the last STOP cycle.
- tx_busy = (state != IDLE), registered with the state.
- FIFO edge cases:
  - Push and pop on the same edge: both take effect; count is unchanged. Ordering is strictly FIFO.
  - Push when full: impossible, because in_ready is 0.
- Reset mid-frame: the frame is abandoned immediately and tx_serial returns to 1 on the reset edge. frame_done does not pulse for the abandoned frame.
- Counter width is $clog2(CLKS_PER_BIT), minimum 1 bit. With CLKS_PER_BIT=1 every state lasts one cycle.

Decomposition:
- Package encoded_serializer_pkg holds:
  - state enum (IDLE, START, DATA, PARITY, STOP);
  - FRAME_BITS=11;
  - DATA_BITS=8.
- One sub-module: byte_fifo2.
  - 2-entry, 8-bit synchronous FIFO with push, pop, full, empty and dout.
  - Synchronous active-low reset.

Test Plan:
1. Reset: hold rst_n low 3 cycles with in_valid=1, in_data=0x55 -> in_ready=0, tx_serial=1, tx_busy=0, frame_done=0. After release no frame starts until a new handshake.
2. CLKS_PER_BIT=4, even parity, send 0xA5 -> tx_serial low 1 cycle after acceptance. Line sequence: 0,1,0,1,0,0,1,0,1,0,1, each bit 4 cycles. frame_done pulses once 44 cycles after the start-bit edge.
3. Hold in_valid high and offer 0x01, 0x80, 0xFF, 0x3C -> first three accepted on consecutive edges. in_ready drops before 0x3C and rises only when the 0x01 frame completes. Frames are contiguous with parity bits 1, 1, 0, 0 and no idle-high gap.
4. PARITY_ODD=1, send 0x00 -> parity bit 1. Send 0x07 -> parity bit 0.
5. Assert rst_n low during DATA bit 3 with one byte queued -> tx_serial=1 on the next edge, FIFO empty, no frame_done. After release, send 0x3C -> correct full frame.
6. CLKS_PER_BIT=1, stream 0xFF continuously for 5 bytes -> five back-to-back 11-cycle frames. tx_busy stays high for 55 cycles and frame_done pulses every 11 cycles.

Source files
------------

// File: rtl/encoded_serializer_pkg.sv
// Shared types and constants for the encoded byte serializer.
package encoded_serializer_pkg;

   localparam int FRAME_BITS = 11;
   localparam int DATA_BITS  = 8;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP
   } state_t;

endpackage

// File: rtl/byte_fifo2.sv
// Two-entry byte FIFO with synchronous active-low reset; push and pop may coincide.
module byte_fifo2
   import encoded_serializer_pkg::*;
(
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 push_i,
   input  logic                 pop_i,
   input  logic [DATA_BITS-1:0] din_i,
   output logic [DATA_BITS-1:0] dout_o,
   output logic                 full_o,
   output logic                 empty_o
);

   logic [DATA_BITS-1:0] mem_q [2];
   logic                 wr_ptr_q;
   logic                 rd_ptr_q;
   logic [1:0]           count_q;
   logic                 do_push;
   logic                 do_pop;

   assign full_o  = (count_q == 2'd2);
   assign empty_o = (count_q == 2'd0);
   assign dout_o  = mem_q[rd_ptr_q];
   assign do_push = push_i && !full_o;
   assign do_pop  = pop_i && !empty_o;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         count_q  <= 2'd0;
         wr_ptr_q <= 1'b0;
         rd_ptr_q <= 1'b0;
      end else begin
         if (do_push) wr_ptr_q <= !wr_ptr_q;
         if (do_pop)  rd_ptr_q <= !rd_ptr_q;
         case ({do_push, do_pop})
            2'b10:   count_q <= count_q + 2'd1;
            2'b01:   count_q <= count_q - 2'd1;
            default: count_q <= count_q;
         endcase
      end
   end

   // Storage needs no reset: the count alone decides what is valid.
   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= din_i;
   end

endmodule

// File: rtl/encoded_byte_serializer.sv
// Serializes buffered bytes as 11-bit frames: start, 8 data LSB-first, parity, stop.
//   state  | meaning
//   IDLE   | line high, waiting for a buffered byte
//   START  | start bit (low)
//   DATA   | data bit idx_q of the shift register
//   PARITY | parity bit over the byte
//   STOP   | stop bit (high); chains straight into START if a byte is waiting
module encoded_byte_serializer
   import encoded_serializer_pkg::*;
#(
   parameter int CLKS_PER_BIT = 4,
   parameter int PARITY_ODD   = 0
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [DATA_BITS-1:0] in_data,
   input  logic                 in_valid,
   output logic                 in_ready,
   output logic                 tx_serial,
   output logic                 tx_busy,
   output logic                 frame_done
);

   localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam int IW = $clog2(DATA_BITS);
   localparam logic [CW-1:0] CYC_LAST = CW'(CLKS_PER_BIT - 1);
   localparam logic [IW-1:0] IDX_LAST = IW'(DATA_BITS - 1);
   localparam logic          PAR_ODD  = (PARITY_ODD != 0);

   state_t               state_q;
   logic [CW-1:0]        cyc_q;
   logic [IW-1:0]        idx_q;
   logic [DATA_BITS-1:0] shreg_q;
   logic                 tx_q;
   logic                 busy_q;
   logic                 done_q;

   logic                 fifo_full;
   logic                 fifo_empty;
   logic [DATA_BITS-1:0] fifo_dout;
   logic                 push;
   logic                 pop;
   logic                 bit_end;
   logic                 parity_bit;

   assign in_ready   = rst_n && !fifo_full;
   assign push       = in_valid && in_ready;
   assign bit_end    = (cyc_q == CYC_LAST);
   assign pop        = !fifo_empty && ((state_q == IDLE) || (state_q == STOP && bit_end));
   assign parity_bit = (^shreg_q) ^ PAR_ODD;

   byte_fifo2 u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .push_i  (push),
      .pop_i   (pop),
      .din_i   (in_data),
      .dout_o  (fifo_dout),
      .full_o  (fifo_full),
      .empty_o (fifo_empty)
   );

   // Line level is registered alongside the state, so each transition loads
   // the level belonging to the state being entered.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cyc_q   <= '0;
         idx_q   <= '0;
         shreg_q <= '0;
         tx_q    <= 1'b1;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (pop) begin
                  shreg_q <= fifo_dout;
                  cyc_q   <= '0;
                  state_q <= START;
                  tx_q    <= 1'b0;
                  busy_q  <= 1'b1;
               end
            end
            START: begin
               if (bit_end) begin
                  cyc_q   <= '0;
                  idx_q   <= '0;
                  state_q <= DATA;
                  tx_q    <= shreg_q[0];
               end else begin
                  cyc_q <= cyc_q + CW'(1);
               end
            end
            DATA: begin
               if (bit_end) begin
                  cyc_q <= '0;
                  if (idx_q == IDX_LAST) begin
                     state_q <= PARITY;
                     tx_q    <= parity_bit;
                  end else begin
                     idx_q <= idx_q + IW'(1);
                     tx_q  <= shreg_q[idx_q + IW'(1)];
                  end
               end else begin
                  cyc_q <= cyc_q + CW'(1);
               end
            end
            PARITY: begin
               if (bit_end) begin
                  cyc_q   <= '0;
                  state_q <= STOP;
                  tx_q    <= 1'b1;
               end else begin
                  cyc_q <= cyc_q + CW'(1);
               end
            end
            STOP: begin
               if (bit_end) begin
                  cyc_q  <= '0;
                  done_q <= 1'b1;
                  if (pop) begin
                     shreg_q <= fifo_dout;
                     state_q <= START;
                     tx_q    <= 1'b0;
                  end else begin
                     state_q <= IDLE;
                     tx_q    <= 1'b1;
                     busy_q  <= 1'b0;
                  end
               end else begin
                  cyc_q <= cyc_q + CW'(1);
               end
            end
            default: begin
               state_q <= IDLE;
               tx_q    <= 1'b1;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign tx_serial  = tx_q;
   assign tx_busy    = busy_q;
   assign frame_done = done_q;

endmodule
